// File: rtl/pa_rst_seq.sv
// Reset-release sequencer: staggers BIU, core and peripheral reset release after cpurst_b,
// and replays the release after a software-requested hold, keeping a sticky software-cause flag.
module pa_rst_seq #(
    parameter int unsigned GAP_CYC   = 8,
    parameter int unsigned SWRST_CYC = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic forever_cpuclk,
    input  logic cpurst_b,
    input  logic pad_yy_scan_mode,
    input  logic pad_yy_scan_rst_b,
    input  logic sw_rst_req,
    input  logic rst_cause_clr,
    output logic rst_biu_rst_b,
    output logic rst_core_rst_b,
    output logic rst_peri_rst_b,
    output logic rst_seq_done,
    output logic rst_sw_ack,
    output logic rst_sw_cause
);

    typedef enum logic [2:0] {
        HOLD,
        REL_BIU,
        REL_CORE,
        RUN,
        SW_HOLD
    } state_e;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SWRST_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             biu_q;
    logic             core_q;
    logic             peri_q;
    logic             done_q;
    logic             ack_q;
    logic             cause_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            biu_q   <= 1'b0;
            core_q  <= 1'b0;
            peri_q  <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            // A clear is overridden below when a software reset starts in the same cycle.
            if (rst_cause_clr) begin
                cause_q <= 1'b0;
            end
            case (state_q)
                HOLD: begin
                    if (cnt_q == GAP_LAST) begin
                        biu_q   <= 1'b1;
                        state_q <= REL_BIU;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                REL_BIU: begin
                    if (cnt_q == GAP_LAST) begin
                        core_q  <= 1'b1;
                        state_q <= REL_CORE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                REL_CORE: begin
                    if (cnt_q == GAP_LAST) begin
                        peri_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        biu_q   <= 1'b0;
                        core_q  <= 1'b0;
                        peri_q  <= 1'b0;
                        done_q  <= 1'b0;
                        cause_q <= 1'b1;
                        state_q <= SW_HOLD;
                        cnt_q   <= '0;
                    end
                end
                SW_HOLD: begin
                    if (cnt_q == SW_LAST) begin
                        ack_q   <= 1'b1;
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= HOLD;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Scan mode hands the domain resets straight to the tester; status outputs stay registered.
    assign rst_biu_rst_b  = pad_yy_scan_mode ? pad_yy_scan_rst_b : biu_q;
    assign rst_core_rst_b = pad_yy_scan_mode ? pad_yy_scan_rst_b : core_q;
    assign rst_peri_rst_b = pad_yy_scan_mode ? pad_yy_scan_rst_b : peri_q;
    assign rst_seq_done   = done_q;
    assign rst_sw_ack     = ack_q;
    assign rst_sw_cause   = cause_q;

endmodule

// File: tb/tb_pa_rst_seq.sv
// Randomised bench for pa_rst_seq: default instance plus a GAP_CYC=1 instance,
// both compared each cycle against an age/hold-count reference model.
module tb_pa_rst_seq;

    localparam int G0 = 8;
    localparam int S0 = 16;
    localparam int G1 = 1;
    localparam int S1 = 3;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic scan_mode  = 1'b0;
    logic scan_rst_b = 1'b1;
    logic req        = 1'b0;
    logic clr        = 1'b0;

    wire [5:0] o0;
    wire [5:0] o1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pa_rst_seq #(.GAP_CYC(G0), .SWRST_CYC(S0), .CNT_W(5)) dut0 (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .pad_yy_scan_mode(scan_mode), .pad_yy_scan_rst_b(scan_rst_b),
        .sw_rst_req(req), .rst_cause_clr(clr),
        .rst_biu_rst_b(o0[5]), .rst_core_rst_b(o0[4]), .rst_peri_rst_b(o0[3]),
        .rst_seq_done(o0[2]), .rst_sw_ack(o0[1]), .rst_sw_cause(o0[0])
    );

    pa_rst_seq #(.GAP_CYC(G1), .SWRST_CYC(S1), .CNT_W(2)) dut1 (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .pad_yy_scan_mode(scan_mode), .pad_yy_scan_rst_b(scan_rst_b),
        .sw_rst_req(req), .rst_cause_clr(clr),
        .rst_biu_rst_b(o1[5]), .rst_core_rst_b(o1[4]), .rst_peri_rst_b(o1[3]),
        .rst_seq_done(o1[2]), .rst_sw_ack(o1[1]), .rst_sw_cause(o1[0])
    );

    // age = edges since the release sequence last started; hold = edges spent in a software hold
    typedef struct {
        int age;
        bit in_sw;
        int hold;
        bit ack;
        bit cause;
    } model_t;

    model_t m0, m1;

    function automatic model_t model_reset();
        model_t m;
        m.age = 0; m.in_sw = 0; m.hold = 0; m.ack = 0; m.cause = 0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, int g, int s, bit rq, bit cl);
        model_t n = m;
        n.ack = 0;
        if (cl) n.cause = 0;
        if (m.in_sw) begin
            n.hold = m.hold + 1;
            if (n.hold == s) begin
                n.in_sw = 0;
                n.age   = 0;
                n.ack   = 1;
            end
        end else if (m.age >= 3 * g) begin
            if (rq) begin
                n.in_sw = 1;
                n.hold  = 0;
                n.cause = 1;
            end
        end else begin
            n.age = m.age + 1;
        end
        return n;
    endfunction

    function automatic logic [5:0] model_out(model_t m, int g, bit sm, bit sr);
        logic b, c, p, d;
        b = !m.in_sw && (m.age >= g);
        c = !m.in_sw && (m.age >= 2 * g);
        p = !m.in_sw && (m.age >= 3 * g);
        d = p;
        if (sm) begin
            b = sr; c = sr; p = sr;
        end
        return {b, c, p, d, m.ack, m.cause};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= model_reset();
            m1 <= model_reset();
        end else begin
            m0 <= model_step(m0, G0, S0, req, clr);
            m1 <= model_step(m1, G1, S1, req, clr);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; clr = 1'b0; scan_mode = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o0 !== 6'b0) begin errors++; $display("FAIL reset_dut0 got=%b exp=%b", o0, 6'b0); end
        checks++;
        if (o1 !== 6'b0) begin errors++; $display("FAIL reset_dut1 got=%b exp=%b", o1, 6'b0); end
    endtask

    task automatic test_power_on();
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            checks++;
            if (o0 !== model_out(m0, G0, scan_mode, scan_rst_b)) begin
                errors++; $display("FAIL power_on_dut0 edge=%0d got=%b exp=%b", k, o0, model_out(m0, G0, scan_mode, scan_rst_b));
            end
            checks++;
            if (o1 !== model_out(m1, G1, scan_mode, scan_rst_b)) begin
                errors++; $display("FAIL power_on_dut1 edge=%0d got=%b exp=%b", k, o1, model_out(m1, G1, scan_mode, scan_rst_b));
            end
            if (k == 7)  begin checks++; if (o0 !== 6'b000000) begin errors++; $display("FAIL edge7_quiet got=%b exp=000000", o0); end end
            if (k == 8)  begin checks++; if (o0[5:2] !== 4'b1000) begin errors++; $display("FAIL edge8_biu got=%b exp=1000", o0[5:2]); end end
            if (k == 16) begin checks++; if (o0[5:2] !== 4'b1100) begin errors++; $display("FAIL edge16_core got=%b exp=1100", o0[5:2]); end end
            if (k == 23) begin checks++; if (o0[5:2] !== 4'b1100) begin errors++; $display("FAIL edge23_pre got=%b exp=1100", o0[5:2]); end end
            if (k == 24) begin checks++; if (o0[5:2] !== 4'b1111) begin errors++; $display("FAIL edge24_peri got=%b exp=1111", o0[5:2]); end end
            if (k == 1)  begin checks++; if (o1[5:2] !== 4'b1000) begin errors++; $display("FAIL gap1_edge1 got=%b exp=1000", o1[5:2]); end end
            if (k == 2)  begin checks++; if (o1[5:2] !== 4'b1100) begin errors++; $display("FAIL gap1_edge2 got=%b exp=1100", o1[5:2]); end end
            if (k == 3)  begin checks++; if (o1[5:2] !== 4'b1111) begin errors++; $display("FAIL gap1_edge3 got=%b exp=1111", o1[5:2]); end end
        end
    endtask

    task automatic test_sw_pulse();
        int ack_seen = 0;
        for (int k = 0; k < 60; k++) begin
            req = (k < 3);
            @(negedge clk);
            checks++;
            if (o0 !== model_out(m0, G0, scan_mode, scan_rst_b)) begin
                errors++; $display("FAIL sw_pulse_dut0 cyc=%0d got=%b exp=%b", k, o0, model_out(m0, G0, scan_mode, scan_rst_b));
            end
            checks++;
            if (o1 !== model_out(m1, G1, scan_mode, scan_rst_b)) begin
                errors++; $display("FAIL sw_pulse_dut1 cyc=%0d got=%b exp=%b", k, o1, model_out(m1, G1, scan_mode, scan_rst_b));
            end
            if (k == 0) begin checks++; if (o0 !== 6'b000001) begin errors++; $display("FAIL sw_entry got=%b exp=000001", o0); end end
            if (k == 16) begin checks++; if (o0 !== 6'b000011) begin errors++; $display("FAIL sw_ack got=%b exp=000011", o0); end end
            if (o0[1]) ack_seen++;
        end
        req = 1'b0;
        checks++;
        if (ack_seen !== 1) begin errors++; $display("FAIL sw_ack_count got=%0d exp=1", ack_seen); end
    endtask

    task automatic test_req_held();
        int acks = 0;
        rst_n = 1'b0; req = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            checks++;
            if (o0 !== model_out(m0, G0, scan_mode, scan_rst_b)) begin
                errors++; $display("FAIL req_held_dut0 edge=%0d got=%b exp=%b", k, o0, model_out(m0, G0, scan_mode, scan_rst_b));
            end
            checks++;
            if (o1 !== model_out(m1, G1, scan_mode, scan_rst_b)) begin
                errors++; $display("FAIL req_held_dut1 edge=%0d got=%b exp=%b", k, o1, model_out(m1, G1, scan_mode, scan_rst_b));
            end
            if (o0[1]) acks++;
        end
        // entry at edge 25, ack at 41, RUN at 65, entry at 66, second ack at 82
        checks++;
        if (acks !== 2) begin errors++; $display("FAIL req_held_acks got=%0d exp=2", acks); end
        req = 1'b0;
        repeat (45) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (o0[5:4] !== 2'b10) begin errors++; $display("FAIL mid_pre got=%b exp=10", o0[5:4]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (o0 !== 6'b0) begin errors++; $display("FAIL mid_async_dut0 got=%b exp=000000", o0); end
        checks++;
        if (o1 !== 6'b0) begin errors++; $display("FAIL mid_async_dut1 got=%b exp=000000", o1); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            checks++;
            if (o0 !== model_out(m0, G0, scan_mode, scan_rst_b)) begin
                errors++; $display("FAIL mid_restart edge=%0d got=%b exp=%b", k, o0, model_out(m0, G0, scan_mode, scan_rst_b));
            end
            if (k == 8) begin checks++; if (o0[5] !== 1'b1) begin errors++; $display("FAIL mid_biu8 got=%b exp=1", o0[5]); end end
        end
    endtask

    task automatic test_cause_clr();
        req = 1'b1; clr = 1'b1;
        @(negedge clk);
        req = 1'b0; clr = 1'b0;
        checks++;
        if (o0[0] !== 1'b1) begin errors++; $display("FAIL cause_set_wins got=%b exp=1", o0[0]); end
        repeat (45) begin
            @(negedge clk);
            checks++;
            if (o0 !== model_out(m0, G0, scan_mode, scan_rst_b)) begin
                errors++; $display("FAIL cause_seq got=%b exp=%b", o0, model_out(m0, G0, scan_mode, scan_rst_b));
            end
        end
        checks++;
        if (o0[0] !== 1'b1) begin errors++; $display("FAIL cause_sticky got=%b exp=1", o0[0]); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (o0[0] !== 1'b0) begin errors++; $display("FAIL cause_clear got=%b exp=0", o0[0]); end
        checks++;
        if (o1 !== model_out(m1, G1, scan_mode, scan_rst_b)) begin
            errors++; $display("FAIL cause_dut1 got=%b exp=%b", o1, model_out(m1, G1, scan_mode, scan_rst_b));
        end
    endtask

    task automatic test_scan();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        scan_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            scan_rst_b = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (o0[5:2] !== {scan_rst_b, scan_rst_b, scan_rst_b, 1'b0}) begin
                errors++; $display("FAIL scan_comb got=%b exp=%b", o0[5:2], {scan_rst_b, scan_rst_b, scan_rst_b, 1'b0});
            end
            @(negedge clk);
            checks++;
            if (o0 !== model_out(m0, G0, scan_mode, scan_rst_b)) begin
                errors++; $display("FAIL scan_dut0 got=%b exp=%b", o0, model_out(m0, G0, scan_mode, scan_rst_b));
            end
        end
        scan_mode = 1'b0; scan_rst_b = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            checks++;
            if (o0 !== model_out(m0, G0, scan_mode, scan_rst_b)) begin
                errors++; $display("FAIL rand_dut0 cyc=%0d got=%b exp=%b", k, o0, model_out(m0, G0, scan_mode, scan_rst_b));
            end
            checks++;
            if (o1 !== model_out(m1, G1, scan_mode, scan_rst_b)) begin
                errors++; $display("FAIL rand_dut1 cyc=%0d got=%b exp=%b", k, o1, model_out(m1, G1, scan_mode, scan_rst_b));
            end
            if ($urandom_range(0, 14) == 0) req = ~req;
            clr = ($urandom_range(0, 9) == 0);
            scan_mode = ($urandom_range(0, 39) == 0);
            scan_rst_b = 1'($urandom_range(0, 1));
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
        end
        req = 1'b0; clr = 1'b0; scan_mode = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_sw_pulse();
        test_req_held();
        test_reset_mid();
        test_cause_clr();
        test_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pa_rst_seq.md
Name: pa_rst_seq

Overview:
- Reset-release sequencer directly downstream of the CPU reset synchronizer.
- Consumes the synchronized `cpurst_b` on `forever_cpuclk` and releases three sub-domain resets in a fixed staggered order: BIU, then core, then peripheral/debug.
- Also executes software-requested subsystem resets: assert all domains, hold for a minimum width, then re-run the release sequence.
- Keeps a sticky reset-cause flag.

Parameters:
- GAP_CYC, 8: cycles between successive domain releases (legal range 1..2^CNT_W).
- SWRST_CYC, 16: cycles all domains are held in reset on a software request (legal range 1..2^CNT_W).
- CNT_W, 5: sequence counter width; must hold max(GAP_CYC, SWRST_CYC)-1.

Ports:
- forever_cpuclk  in  1  free-running CPU clock.
- cpurst_b  in  1  asynchronous active-low reset (synchronized deassertion upstream).
- pad_yy_scan_mode  in  1  scan mode select.
- pad_yy_scan_rst_b  in  1  scan reset, active low.
- sw_rst_req  in  1  software subsystem-reset request (level, held until ack).
- rst_cause_clr  in  1  one-cycle clear of the reset-cause flag.
- rst_biu_rst_b  out  1  BIU domain reset, active low.
- rst_core_rst_b  out  1  core domain reset, active low.
- rst_peri_rst_b  out  1  peripheral/debug domain reset, active low.
- rst_seq_done  out  1  high when all domains are released.
- rst_sw_ack  out  1  one-cycle pulse when a software reset hold completes.
- rst_sw_cause  out  1  sticky flag: last subsystem reset was software-initiated.

Behaviour:
- Clock and reset: one clock `forever_cpuclk`; reset `cpurst_b` is asynchronous, active-low.
- While `cpurst_b`=0:
  - state=HOLD, counter=0.
  - All domain reset flops=0, `rst_seq_done`=0, `rst_sw_ack`=0, `rst_sw_cause`=0.
- Outputs come directly from flops (glitch-free). The only exception is the scan mux described below.
- States: HOLD, REL_BIU, REL_CORE, RUN, SW_HOLD.
- Release sequence. Edge n = nth rising edge with `cpurst_b`=1.
  - HOLD counts 0..GAP_CYC-1. At edge GAP_CYC: `rst_biu_rst_b`->1, state=REL_BIU, counter=0.
  - REL_BIU counts GAP_CYC cycles. At edge 2*GAP_CYC: `rst_core_rst_b`->1, state=REL_CORE.
  - REL_CORE counts GAP_CYC cycles. At edge 3*GAP_CYC: `rst_peri_rst_b`->1 and `rst_seq_done`->1 on the same edge, state=RUN.
  - GAP_CYC=1 gives releases at edges 1, 2, 3.
- Software reset:
  - `sw_rst_req` is sampled only in RUN.
  - Req=1 in RUN: at the next edge all three domain resets->0 together, `rst_seq_done`->0, `rst_sw_cause`->1, counter=0, state=SW_HOLD.
  - SW_HOLD lasts SWRST_CYC cycles. On the edge leaving it: `rst_sw_ack`=1 for exactly one cycle, state=HOLD, counter=0. The full release sequence then repeats, timed from that edge.
  - `sw_rst_req` is ignored in HOLD, REL_BIU, REL_CORE and SW_HOLD.
  - If req is still high on RUN entry, a new software reset starts. The requester must drop req after seeing ack.
- Cause flag:
  - `rst_cause_clr`=1 clears `rst_sw_cause` at the next edge.
  - If set and clear occur in the same cycle, set wins.
  - The flag is cleared only by `cpurst_b` or `rst_cause_clr`; it is not cleared by the release sequence.
- Reset mid-operation: `cpurst_b` falling in any state immediately (asynchronously) returns everything to reset values. A sequence interrupted in progress is never resumed.
- Scan mode: when `pad_yy_scan_mode`=1, all three domain reset outputs = `pad_yy_scan_rst_b` combinationally. `rst_seq_done`, `rst_sw_ack` and `rst_sw_cause` remain flop outputs.
- Counter never wraps: it is cleared on every state change and compared to its limit-1.

Test Plan:
- Defaults, release `cpurst_b`: biu rises at edge 8, core at edge 16, peri and done at edge 24; no output changes before edge 8.
- RUN, pulse `sw_rst_req` high for 3 cycles:
  - All resets low one edge after sampling, cause=1.
  - Ack pulse exactly 16 cycles later, one cycle wide.
  - biu/core/peri re-release 8/16/24 edges after the ack edge.
- `sw_rst_req` held high through the whole sequence after power-on reset: no effect until RUN; ack a second time if still held after re-release.
- `cpurst_b` asserted at edge 12 (BIU released, core not): all outputs 0 asynchronously. After deassertion the timing restarts from edge 1 (biu at 8).
- `rst_cause_clr` and a software-reset entry in the same cycle: cause=1. A later lone clear gives cause=0.
- Scan mode=1 with `pad_yy_scan_rst_b` toggling during HOLD: all three domain resets follow the scan reset; done stays 0. GAP_CYC=1 regression: releases at edges 1, 2, 3.
